// File: rtl/pa_sub.sv
// Registered ripple-borrow subtractor: {bo, d} <= a - b - c.
// Widen by chaining bo of a lower slice into c of the next.
module pa_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    logic [WIDTH-1:0] diff;
    logic             br_out;

    // Full-subtractor chain; br carries the borrow from bit i to bit i+1.
    always_comb begin
        logic br;
        br   = c;
        diff = '0;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i] = a[i] ^ b[i] ^ br;
            br      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        br_out = br;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d  <= '0;
            bo <= 1'b0;
        end else begin
            d  <= diff;
            bo <= br_out;
        end
    end

endmodule

// File: tb/tb_pa_sub.sv
// Scoreboard bench for pa_sub at WIDTH=4 and WIDTH=8.
// Expected {bo, d} are queued at drive time and popped one cycle later.
module tb_pa_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a4, b4, d4;
    logic       c4, bo4;
    logic [7:0] a8, b8, d8;
    logic       c8, bo8;

    logic [4:0] q4[$];
    logic [8:0] q8[$];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pa_sub #(.WIDTH(4)) u_sub4 (
        .clk(clk), .rst_n(rst_n),
        .a(a4), .b(b4), .c(c4),
        .d(d4), .bo(bo4)
    );

    pa_sub #(.WIDTH(8)) u_sub8 (
        .clk(clk), .rst_n(rst_n),
        .a(a8), .b(b8), .c(c8),
        .d(d8), .bo(bo8)
    );

    task automatic test_reset_state();
        #1;
        vectors++;
        if ({bo4, d4} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_state4 got=%b want=%b", {bo4, d4}, 5'b0);
        end
        vectors++;
        if ({bo8, d8} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_state8 got=%b want=%b", {bo8, d8}, 9'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [8:0] stim [8] = '{
            9'b0000_0000_0, 9'b0000_0000_1,
            9'b1111_1111_0, 9'b1111_1111_1,
            9'b1010_0101_0, 9'b1010_0101_1,
            9'b0101_1010_0, 9'b0101_1010_1
        };
        logic [4:0] want [8] = '{
            5'b0_0000, 5'b1_1111,
            5'b0_0000, 5'b1_1111,
            5'b0_0101, 5'b0_0100,
            5'b1_1011, 5'b1_1010
        };
        logic [4:0] e;
        for (int k = 0; k < 8; k++) begin
            {a4, b4, c4} = stim[k];
            q4.push_back(want[k]);
            @(posedge clk);
            #1;
            e = q4.pop_front();
            vectors++;
            if ({bo4, d4} !== e) begin
                miscompares++;
                $display("FAIL directed[%0d] a=%b b=%b c=%b got=%b want=%b",
                         k, a4, b4, c4, {bo4, d4}, e);
            end
        end
    endtask

    task automatic test_reset();
        logic [4:0] e;
        a4 = 4'b0101; b4 = 4'b1010; c4 = 1'b1;
        q4.push_back(5'b1_1010);
        @(posedge clk);
        #1;
        e = q4.pop_front();
        vectors++;
        if ({bo4, d4} !== e) begin
            miscompares++;
            $display("FAIL rst_preload got=%b want=%b", {bo4, d4}, e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bo4, d4} !== 5'b0) begin
            miscompares++;
            $display("FAIL rst_async got=%b want=%b", {bo4, d4}, 5'b0);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({bo4, d4} !== 5'b0) begin
            miscompares++;
            $display("FAIL rst_hold got=%b want=%b", {bo4, d4}, 5'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q4.push_back(5'b1_1010);
        @(posedge clk);
        #1;
        e = q4.pop_front();
        vectors++;
        if ({bo4, d4} !== e) begin
            miscompares++;
            $display("FAIL rst_release got=%b want=%b", {bo4, d4}, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] v;
        logic [4:0] e;
        for (int n = 0; n < 512; n++) begin
            v = 9'(n);
            {a4, b4, c4} = v;
            q4.push_back(5'({1'b0, a4} - {1'b0, b4} - {4'b0, c4}));
            @(posedge clk);
            #1;
            e = q4.pop_front();
            vectors++;
            if ({bo4, d4} !== e) begin
                miscompares++;
                $display("FAIL sweep4 a=%b b=%b c=%b got=%b want=%b",
                         a4, b4, c4, {bo4, d4}, e);
            end
        end
    endtask

    task automatic test_width8();
        logic [8:0] e;
        for (int n = 0; n < 202; n++) begin
            if (n == 0) begin
                a8 = 8'h00; b8 = 8'hFF; c8 = 1'b1;
                q8.push_back(9'b1_0000_0000);
            end else if (n == 1) begin
                a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
                q8.push_back(9'b1_1111_1111);
            end else begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                c8 = 1'($urandom);
                q8.push_back(9'({1'b0, a8} - {1'b0, b8} - {8'b0, c8}));
            end
            @(posedge clk);
            #1;
            e = q8.pop_front();
            vectors++;
            if ({bo8, d8} !== e) begin
                miscompares++;
                $display("FAIL sweep8 a=%h b=%h c=%b got=%b want=%b",
                         a8, b8, c8, {bo8, d8}, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a4 = '0; b4 = '0; c4 = 1'b0;
        a8 = '0; b8 = '0; c8 = 1'b0;
        test_reset_state();
        test_directed();
        test_reset();
        test_back_to_back();
        test_width8();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
